// File: rtl/game_move_ctrl.sv
// Grid-based person/box mover: synchronizes and debounces four direction buttons,
// evaluates one move per press (with box pushing) and drives registered pixel centres.
module game_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int H_MIN           = 100,
  parameter int H_STEP          = 65,
  parameter int COLS            = 10,
  parameter int V_MIN           = 100,
  parameter int V_STEP          = 100,
  parameter int ROWS            = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  direction,
  output logic [10:0] people_center_h,
  output logic [10:0] people_center_v,
  output logic [10:0] box_center_h,
  output logic [10:0] box_center_v,
  output logic        move_done,
  output logic        blocked
);

  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] EVAL         = 2'd1;
  localparam logic [1:0] COMMIT       = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  localparam logic [CW-1:0] PERSON_COL0 = CW'(0);
  localparam logic [RW-1:0] PERSON_ROW0 = RW'(2);
  localparam logic [CW-1:0] BOX_COL0    = CW'(1);
  localparam logic [RW-1:0] BOX_ROW0    = RW'(2);

  logic [3:0]     sync_p0, sync_p1, deb;
  logic [DBW-1:0] cnt [4];
  logic [1:0]     state;
  logic [3:0]     dir_q;
  logic [CW-1:0]  person_col, box_col;
  logic [RW-1:0]  person_row, box_row;

  int   dc, dr, tc, tr, bc, br;
  logic push, ok, one_hot;

  function automatic logic in_range(input int c, input int r);
    return (c >= 0) && (c < COLS) && (r >= 0) && (r < ROWS);
  endfunction

  function automatic logic [10:0] pix_h(input logic [CW-1:0] col);
    return 11'(H_MIN + int'(col) * H_STEP);
  endfunction

  function automatic logic [10:0] pix_v(input logic [RW-1:0] row);
    return 11'(V_MIN + int'(row) * V_STEP);
  endfunction

  // Stage p0/p1: two-flop synchronizer, then per-bit debounce on the synchronized level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb     <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= direction;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] != deb[i]) begin
          if (cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= sync_p1[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + DBW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign one_hot = (deb != 4'b0000) && ((deb & (deb - 4'd1)) == 4'b0000);

  // Direction is captured on the IDLE->EVAL edge, so later button activity cannot alter it
  always_ff @(posedge clk) begin
    if (state == IDLE) dir_q <= deb;
  end

  always_comb begin
    dc = 0;
    dr = 0;
    case (dir_q)
      4'b1000: dr = -1;
      4'b0100: dr = 1;
      4'b0010: dc = -1;
      4'b0001: dc = 1;
      default: ;
    endcase
    tc   = int'(person_col) + dc;
    tr   = int'(person_row) + dr;
    push = (tc == int'(box_col)) && (tr == int'(box_row));
    bc   = push ? int'(box_col) + dc : int'(box_col);
    br   = push ? int'(box_row) + dr : int'(box_row);
    ok   = in_range(tc, tr) && (!push || in_range(bc, br));
  end

  // Evaluated move is committed on the edge leaving EVAL; pulses are visible during COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      person_col <= PERSON_COL0;
      person_row <= PERSON_ROW0;
      box_col    <= BOX_COL0;
      box_row    <= BOX_ROW0;
      move_done  <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      move_done <= 1'b0;
      blocked   <= 1'b0;
      case (state)
        IDLE: if (one_hot) state <= EVAL;
        EVAL: begin
          state <= COMMIT;
          if (ok) begin
            person_col <= CW'(tc);
            person_row <= RW'(tr);
            box_col    <= CW'(bc);
            box_row    <= RW'(br);
            move_done  <= 1'b1;
          end else begin
            blocked <= 1'b1;
          end
        end
        COMMIT:       state <= WAIT_RELEASE;
        WAIT_RELEASE: if (deb == 4'b0000) state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

  // Stage p2: pixel centres registered from the grid state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      people_center_h <= pix_h(PERSON_COL0);
      people_center_v <= pix_v(PERSON_ROW0);
      box_center_h    <= pix_h(BOX_COL0);
      box_center_v    <= pix_v(BOX_ROW0);
    end else begin
      people_center_h <= pix_h(person_col);
      people_center_v <= pix_v(person_row);
      box_center_h    <= pix_h(box_col);
      box_center_v    <= pix_v(box_row);
    end
  end

endmodule

// File: tb/tb_game_move_ctrl.sv
// Bench for game_move_ctrl: directed scenarios plus random presses against a grid model.
module tb_game_move_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  direction;
  logic [10:0] people_center_h, people_center_v, box_center_h, box_center_v;
  logic        move_done, blocked;

  int total = 0;
  int bad   = 0;
  int md_cnt = 0, bl_cnt = 0, both_cnt = 0;

  // reference grid state
  int m_pc, m_pr, m_bc, m_br;

  game_move_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .direction(direction),
    .people_center_h(people_center_h), .people_center_v(people_center_v),
    .box_center_h(box_center_h), .box_center_v(box_center_v),
    .move_done(move_done), .blocked(blocked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (move_done) md_cnt++;
    if (blocked) bl_cnt++;
    if (move_done && blocked) both_cnt++;
  end

  task automatic do_reset();
    rst = 1'b1;
    direction = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_pc = 0; m_pr = 2; m_bc = 1; m_br = 2;
  endtask

  task automatic press(input logic [3:0] d, input int hold, output int mv, output int bl);
    int m0, b0;
    m0 = md_cnt;
    b0 = bl_cnt;
    direction = d;
    repeat (hold) @(negedge clk);
    direction = 4'b0000;
    repeat (16) @(negedge clk);
    mv = md_cnt - m0;
    bl = bl_cnt - b0;
  endtask

  // 0 = no effect, 1 = move, 2 = blocked; updates the model on a move
  function automatic int model_press(input logic [3:0] d);
    int dx, dy, nx, ny, bx, by;
    bit pushes;
    dx = 0; dy = 0;
    if (d == 4'b1000) dy = -1;
    else if (d == 4'b0100) dy = 1;
    else if (d == 4'b0010) dx = -1;
    else if (d == 4'b0001) dx = 1;
    else return 0;
    nx = m_pc + dx; ny = m_pr + dy;
    pushes = (nx == m_bc) && (ny == m_br);
    bx = pushes ? m_bc + dx : m_bc;
    by = pushes ? m_br + dy : m_br;
    if (nx < 0 || nx > 9 || ny < 0 || ny > 4) return 2;
    if (bx < 0 || bx > 9 || by < 0 || by > 4) return 2;
    m_pc = nx; m_pr = ny; m_bc = bx; m_br = by;
    return 1;
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (people_center_h !== 11'd100) begin bad++; $display("FAIL reset_ph got=%0d exp=100", people_center_h); end
    total++; if (people_center_v !== 11'd300) begin bad++; $display("FAIL reset_pv got=%0d exp=300", people_center_v); end
    total++; if (box_center_h !== 11'd165) begin bad++; $display("FAIL reset_bh got=%0d exp=165", box_center_h); end
    total++; if (box_center_v !== 11'd300) begin bad++; $display("FAIL reset_bv got=%0d exp=300", box_center_v); end
    total++; if (move_done !== 1'b0 || blocked !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", move_done, blocked); end
  endtask

  task automatic test_push_right();
    int mv, bl;
    do_reset();
    press(4'b0001, 10, mv, bl);
    total++; if (mv !== 1 || bl !== 0) begin bad++; $display("FAIL push_pulses got mv=%0d bl=%0d exp 1 0", mv, bl); end
    total++; if (people_center_h !== 11'd165) begin bad++; $display("FAIL push_ph got=%0d exp=165", people_center_h); end
    total++; if (box_center_h !== 11'd230) begin bad++; $display("FAIL push_bh got=%0d exp=230", box_center_h); end
    total++; if (people_center_v !== 11'd300 || box_center_v !== 11'd300) begin bad++; $display("FAIL push_v got=%0d/%0d exp=300/300", people_center_v, box_center_v); end
  endtask

  task automatic test_blocked_left();
    int mv, bl;
    do_reset();
    press(4'b0010, 10, mv, bl);
    total++; if (mv !== 0 || bl !== 1) begin bad++; $display("FAIL left_pulses got mv=%0d bl=%0d exp 0 1", mv, bl); end
    total++; if (people_center_h !== 11'd100 || box_center_h !== 11'd165) begin bad++; $display("FAIL left_pos got=%0d/%0d exp=100/165", people_center_h, box_center_h); end
  endtask

  task automatic test_long_hold();
    int mv, bl;
    do_reset();
    press(4'b0001, 200, mv, bl);
    total++; if (mv !== 1 || bl !== 0) begin bad++; $display("FAIL hold_pulses got mv=%0d bl=%0d exp 1 0", mv, bl); end
    total++; if (people_center_h !== 11'd165 || box_center_h !== 11'd230) begin bad++; $display("FAIL hold_pos got=%0d/%0d exp=165/230", people_center_h, box_center_h); end
  endtask

  task automatic test_multi_bit();
    int mv, bl;
    do_reset();
    press(4'b1010, 20, mv, bl);
    total++; if (mv !== 0 || bl !== 0) begin bad++; $display("FAIL multi_pulses got mv=%0d bl=%0d exp 0 0", mv, bl); end
    total++; if (people_center_h !== 11'd100) begin bad++; $display("FAIL multi_pos got=%0d exp=100", people_center_h); end
    press(4'b0001, 10, mv, bl);
    total++; if (mv !== 1 || people_center_h !== 11'd165) begin bad++; $display("FAIL multi_then_right got mv=%0d ph=%0d exp 1 165", mv, people_center_h); end
  endtask

  task automatic test_push_to_wall();
    int mv, bl, moves;
    do_reset();
    moves = 0;
    for (int i = 0; i < 8; i++) begin
      press(4'b0001, 8, mv, bl);
      moves += mv;
    end
    total++; if (moves !== 8) begin bad++; $display("FAIL wall_moves got=%0d exp=8", moves); end
    total++; if (box_center_h !== 11'd685 || people_center_h !== 11'd620) begin bad++; $display("FAIL wall_pos got=%0d/%0d exp=620/685", people_center_h, box_center_h); end
    press(4'b0001, 8, mv, bl);
    total++; if (mv !== 0 || bl !== 1) begin bad++; $display("FAIL wall_ninth got mv=%0d bl=%0d exp 0 1", mv, bl); end
    total++; if (people_center_h !== 11'd620 || box_center_h !== 11'd685) begin bad++; $display("FAIL wall_hold got=%0d/%0d exp=620/685", people_center_h, box_center_h); end
  endtask

  task automatic test_glitch();
    int mv, bl;
    do_reset();
    press(4'b1000, 2, mv, bl);
    total++; if (mv !== 0 || bl !== 0) begin bad++; $display("FAIL glitch_pulses got mv=%0d bl=%0d exp 0 0", mv, bl); end
    total++; if (people_center_v !== 11'd300) begin bad++; $display("FAIL glitch_pos got=%0d exp=300", people_center_v); end
  endtask

  task automatic test_timing();
    bit found;
    do_reset();
    found = 0;
    direction = 4'b0001;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (move_done) begin
        found = 1;
        total++; if (people_center_h !== 11'd100) begin bad++; $display("FAIL timing_during got=%0d exp=100", people_center_h); end
        @(negedge clk);
        total++; if (people_center_h !== 11'd165) begin bad++; $display("FAIL timing_after got=%0d exp=165", people_center_h); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL timing_timeout got=none exp=move_done"); end
    direction = 4'b0000;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset_mid_commit();
    bit found;
    do_reset();
    found = 0;
    direction = 4'b0001;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (move_done) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL midrst_timeout got=none exp=move_done"); end
    rst = 1'b1;
    #1;
    total++; if (move_done !== 1'b0 || blocked !== 1'b0) begin bad++; $display("FAIL midrst_pulses got=%b%b exp=00", move_done, blocked); end
    total++; if (people_center_h !== 11'd100 || box_center_h !== 11'd165) begin bad++; $display("FAIL midrst_pos got=%0d/%0d exp=100/165", people_center_h, box_center_h); end
    direction = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (move_done !== 1'b0 || people_center_h !== 11'd100) begin bad++; $display("FAIL midrst_after got md=%b ph=%0d exp 0 100", move_done, people_center_h); end
  endtask

  task automatic test_random();
    int mv, bl, kind, hold, res;
    logic [3:0] d;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        d = 4'b0001 << $urandom_range(0, 3);
        hold = $urandom_range(6, 25);
      end else if (kind <= 7) begin
        d = 4'b0001 << $urandom_range(0, 3);
        hold = $urandom_range(1, 2);
      end else begin
        d = 4'($urandom_range(0, 15));
        hold = $urandom_range(6, 25);
      end
      res = (hold >= 4) ? model_press(d) : 0;
      press(d, hold, mv, bl);
      total++; if (mv !== ((res == 1) ? 1 : 0) || bl !== ((res == 2) ? 1 : 0)) begin bad++; $display("FAIL rand_pulses n=%0d d=%b got mv=%0d bl=%0d exp res=%0d", n, d, mv, bl, res); end
      total++; if (people_center_h !== 11'(100 + 65 * m_pc) || people_center_v !== 11'(100 + 100 * m_pr)) begin bad++; $display("FAIL rand_person n=%0d got=%0d,%0d exp=%0d,%0d", n, people_center_h, people_center_v, 100 + 65 * m_pc, 100 + 100 * m_pr); end
      total++; if (box_center_h !== 11'(100 + 65 * m_bc) || box_center_v !== 11'(100 + 100 * m_br)) begin bad++; $display("FAIL rand_box n=%0d got=%0d,%0d exp=%0d,%0d", n, box_center_h, box_center_v, 100 + 65 * m_bc, 100 + 100 * m_br); end
    end
  endtask

  initial begin
    rst = 1'b1;
    direction = 4'b0000;
    test_reset();
    test_push_right();
    test_blocked_left();
    test_long_hold();
    test_multi_bit();
    test_push_to_wall();
    test_glitch();
    test_timing();
    test_reset_mid_commit();
    test_random();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
